uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one 8N1 serial transmit line between two byte requesters.
// Optional feature: define UART_ARB_PARITY_EN to append an even-parity bit to each frame.
module uart_tx_arbiter #(
    parameter int CLKDIV = 106
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       ser_tx,
    output logic       busy,
    output logic       grant_id
);
    localparam int W = $clog2(CLKDIV);
    localparam logic [W-1:0] DIV_LAST = W'(CLKDIV - 1);
`ifdef UART_ARB_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t       state;
    logic [W-1:0] div;
    logic [2:0]   bit_idx;
    logic [7:0]   data;
    logic         last;
    logic         grant;
    logic         tick;

    assign tick = div == DIV_LAST;

    // A contested request goes to whichever requester was not served last.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? !last : req1_valid;
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid && grant;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ser_tx   <= 1'b1;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            bit_idx  <= '0;
            div      <= '0;
            last     <= 1'b1;
            data     <= '0;
        end else if (state == IDLE) begin
            div <= '0;
            if (req0_ready || req1_ready) begin
                data     <= grant ? req1_data : req0_data;
                grant_id <= grant;
                last     <= grant;
                state    <= START;
                ser_tx   <= 1'b0;
                busy     <= 1'b1;
            end
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_idx <= '0;
                        ser_tx  <= data[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
                            state  <= PARITY;
                            ser_tx <= ^data;
`else
                            state  <= STOP;
                            ser_tx <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            ser_tx  <= data[bit_idx + 3'd1];
                        end
                    end
`ifdef UART_ARB_PARITY_EN
                    PARITY: begin
                        state  <= STOP;
                        ser_tx <= 1'b1;
                    end
`endif
                    default: begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        ser_tx <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; a grant/timing model predicts frames, a UART monitor decodes ser_tx.
// Honours UART_ARB_PARITY_EN for frame length and parity checking.
module tb_uart_tx_arbiter;
    localparam int C = 106;
    localparam int H = C / 2;
`ifdef UART_ARB_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    typedef struct {
        logic       id;
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 0;
    logic       resetn = 0;
    logic       req0_valid = 0;
    logic       req1_valid = 0;
    logic [7:0] req0_data = 0;
    logic [7:0] req1_data = 0;
    logic       req0_ready, req1_ready, ser_tx, busy, grant_id;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   epoch = 0;
    int   free_at = 0;
    logic m_last = 1;
    logic m_gid = 0;
    logic hs0 = 0;
    logic hs1 = 0;

    uart_tx_arbiter #(.CLKDIV(C)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .ser_tx(ser_tx), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the line is free once a whole frame has elapsed since the last grant.
    always @(negedge clk) begin
        logic midle, w;
        exp_t e;
        if (!resetn) begin
            q.delete();
            epoch++;
            m_last  = 1;
            m_gid   = 0;
            free_at = 0;
        end else begin
            midle = cyc >= free_at;
            check("busy", busy, !midle);
            check("grant_id", grant_id, m_gid);
            if (midle && (req0_valid || req1_valid)) begin
                w = (req0_valid && req1_valid) ? !m_last : req1_valid;
                check("ready", {req1_ready, req0_ready}, w ? 2 : 1);
                e.id    = w;
                e.data  = w ? req1_data : req0_data;
                e.start = cyc + 1;
                q.push_back(e);
                m_last  = w;
                m_gid   = w;
                free_at = cyc + 1 + FB * C;
            end else
                check("no_ready", {req1_ready, req0_ready}, 0);
        end
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
    end

    initial begin : monitor
        int s, ep;
        logic gid;
        logic prev;
        logic [10:0] f;
        exp_t e;
        prev = 1;
        f = '0;
        forever begin
            @(negedge clk);
            if (resetn && prev && !ser_tx) begin
                s   = cyc;
                ep  = epoch;
                gid = grant_id;
                repeat (H) @(negedge clk);
                f[0] = ser_tx;
                for (int i = 1; i < FB; i++) begin
                    repeat (C) @(negedge clk);
                    f[i] = ser_tx;
                end
                if (ep == epoch) begin
                    check("frame_expected", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("start_cycle", s, e.start);
                        check("data", f[8:1], e.data);
                        check("frame_id", gid, e.id);
                        check("start_bit", f[0], 0);
                        check("stop_bit", f[FB-1], 1);
`ifdef UART_ARB_PARITY_EN
                        check("parity", f[9], ^e.data);
`endif
                    end
                end
            end
            prev = ser_tx;
        end
    end

    task automatic run(input int n0, input logic [7:0] d0, input int n1, input logic [7:0] d1);
        int c0, c1, t;
        c0 = 0;
        c1 = 0;
        t  = 0;
        req0_data  = d0;
        req1_data  = d1;
        req0_valid = n0 > 0;
        req1_valid = n1 > 0;
        while ((c0 < n0 || c1 < n1) && t < (n0 + n1 + 1) * (FB * C + 2)) begin
            @(posedge clk);
            #1;
            t++;
            if (hs0) begin c0++; req0_valid = c0 < n0; end
            if (hs1) begin c1++; req1_valid = c1 < n1; end
        end
        check("handshakes", c0 + c1, n0 + n1);
        req0_valid = 0;
        req1_valid = 0;
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("rst_ser_tx", ser_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        @(posedge clk);
        #1 resetn = 1;
        run(2, 8'h41, 2, 8'h42);
        run(1, 8'h48, 0, 8'h00);
        run(0, 8'h00, 1, 8'h0A);
        run(1, 8'h30, 1, 8'h31);
        run(0, 8'h00, 1, 8'h33);
        repeat (200) @(posedge clk);
        #1 run(1, 8'h55, 0, 8'h00);
        req0_data = 8'hAA;
        req1_data = 8'hFF;
`ifdef UART_ARB_PARITY_EN
        run(1, 8'h07, 0, 8'h00);
        run(0, 8'h00, 1, 8'h03);
`endif
        // Abort a frame during data bit 3 of 0x50 (a 0 bit) with an asynchronous reset.
        run(1, 8'h50, 0, 8'h00);
        repeat (4 * C + 20) @(posedge clk);
        #1 check("pre_rst_tx", ser_tx, 0);
        #1 resetn = 0;
        #1 check("abort_ser_tx", ser_tx, 1);
        check("abort_busy", busy, 0);
        check("abort_grant", grant_id, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        repeat (FB * C) @(posedge clk);
        #1 run(1, 8'h7E, 1, 8'h11);
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (hs0 || (req0_valid && $urandom_range(63) == 0)) req0_valid = 0;
            else if (!req0_valid && $urandom_range(7) == 0) begin
                req0_valid = 1;
                req0_data  = 8'($urandom);
            end
            if (hs1 || (req1_valid && $urandom_range(63) == 0)) req1_valid = 0;
            else if (!req1_valid && $urandom_range(7) == 0) begin
                req1_valid = 1;
                req1_data  = 8'($urandom);
            end
        end
        req0_valid = 0;
        req1_valid = 0;
        t = 0;
        while (q.size() != 0 && t < 3 * FB * C) begin
            @(posedge clk);
            t++;
        end
        repeat (C) @(posedge clk);
        check("drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
